// File: rtl/traffic_intersection.sv
// Two-approach traffic controller with pedestrian walk phase and night flash mode.
// Lamp outputs are registered from the next-state decode, so they change on the same edge as the state.
module traffic_intersection #(
    parameter int GREEN_A_DELAY    = 6,
    parameter int GREEN_B_DELAY    = 4,
    parameter int MIN_GREEN        = 2,
    parameter int ORANGE_DELAY     = 1,
    parameter int RED_ORANGE_DELAY = 1,
    parameter int ALL_RED_DELAY    = 1,
    parameter int WALK_DELAY       = 3,
    parameter int FLASH_PERIOD     = 5,
    parameter int COUNTER_WIDTH    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    input  logic flash_en,
    output logic red_a,
    output logic orange_a,
    output logic green_a,
    output logic red_b,
    output logic orange_b,
    output logic green_b,
    output logic walk,
    output logic ped_waiting
);

    typedef enum logic [3:0] {
        ALL_RED_1,
        ALL_RED_2,
        WALK,
        A_RED_ORANGE,
        A_GREEN,
        A_ORANGE,
        B_RED_ORANGE,
        B_GREEN,
        B_ORANGE,
        FLASH
    } state_t;

    state_t                   state, state_next;
    logic [COUNTER_WIDTH-1:0] cnt, cnt_next;
    logic                     ped_pending, ped_pending_next;
    logic                     blink, blink_next;
    logic                     from_ar2, from_ar2_next;
    logic                     ped_set, ped_any, entering;
    logic [6:0]               lamps, lamps_next;

    function automatic logic done(input logic [COUNTER_WIDTH-1:0] c, input int d);
        return c == COUNTER_WIDTH'(d - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALL_RED_2;
            cnt         <= '0;
            ped_pending <= 1'b0;
            blink       <= 1'b0;
            from_ar2    <= 1'b1;
            lamps       <= 7'b1001000;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            ped_pending <= ped_pending_next;
            blink       <= blink_next;
            from_ar2    <= from_ar2_next;
            lamps       <= lamps_next;
        end
    end

    always_comb begin
        ped_set       = ped_req && (state != WALK) && (state != FLASH);
        // A press arriving on the last all-red cycle still diverts into WALK.
        ped_any       = ped_pending | ped_set;
        state_next    = state;
        from_ar2_next = from_ar2;
        if (flash_en) begin
            state_next = FLASH;
        end else begin
            case (state)
                A_RED_ORANGE: if (done(cnt, RED_ORANGE_DELAY)) state_next = A_GREEN;
                A_GREEN:
                    if (done(cnt, GREEN_A_DELAY) ||
                        (ped_pending && cnt >= COUNTER_WIDTH'(MIN_GREEN - 1)))
                        state_next = A_ORANGE;
                A_ORANGE:     if (done(cnt, ORANGE_DELAY)) state_next = ALL_RED_1;
                ALL_RED_1:
                    if (done(cnt, ALL_RED_DELAY)) begin
                        from_ar2_next = 1'b0;
                        state_next    = ped_any ? WALK : B_RED_ORANGE;
                    end
                B_RED_ORANGE: if (done(cnt, RED_ORANGE_DELAY)) state_next = B_GREEN;
                B_GREEN:
                    if (done(cnt, GREEN_B_DELAY) ||
                        (ped_pending && cnt >= COUNTER_WIDTH'(MIN_GREEN - 1)))
                        state_next = B_ORANGE;
                B_ORANGE:     if (done(cnt, ORANGE_DELAY)) state_next = ALL_RED_2;
                ALL_RED_2:
                    if (done(cnt, ALL_RED_DELAY)) begin
                        from_ar2_next = 1'b1;
                        state_next    = ped_any ? WALK : A_RED_ORANGE;
                    end
                WALK:
                    if (done(cnt, WALK_DELAY))
                        state_next = from_ar2 ? A_RED_ORANGE : B_RED_ORANGE;
                FLASH:        state_next = ALL_RED_2;
                default:      state_next = ALL_RED_2;
            endcase
        end

        entering = (state_next != state);
        if (entering || (state == FLASH && done(cnt, FLASH_PERIOD)))
            cnt_next = '0;
        else
            cnt_next = cnt + 1'b1;

        if (entering && state_next == FLASH)
            blink_next = 1'b1;
        else if (state == FLASH && done(cnt, FLASH_PERIOD))
            blink_next = ~blink;
        else
            blink_next = blink;

        if (entering && (state_next == WALK || state_next == FLASH))
            ped_pending_next = 1'b0;
        else
            ped_pending_next = ped_any;
    end

    // Order: red_a, orange_a, green_a, red_b, orange_b, green_b, walk
    always_comb begin
        lamps_next = 7'b1001000;
        case (state_next)
            A_RED_ORANGE: lamps_next = 7'b1101000;
            A_GREEN:      lamps_next = 7'b0011000;
            A_ORANGE:     lamps_next = 7'b0101000;
            B_RED_ORANGE: lamps_next = 7'b1001100;
            B_GREEN:      lamps_next = 7'b1000010;
            B_ORANGE:     lamps_next = 7'b1000100;
            WALK:         lamps_next = 7'b1001001;
            FLASH:        lamps_next = {1'b0, blink_next, 2'b00, blink_next, 2'b00};
            default:      lamps_next = 7'b1001000;
        endcase
    end

    assign {red_a, orange_a, green_a, red_b, orange_b, green_b, walk} = lamps;
    assign ped_waiting = ped_pending;

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench for traffic_intersection: lamp vectors checked one cycle at a time against hand-derived sequences.
module tb_traffic_intersection;

    logic clk = 1'b0;
    logic rst, ped_req, flash_en;
    logic red_a, orange_a, green_a, red_b, orange_b, green_b, walk, ped_waiting;

    int tests  = 0;
    int failed = 0;

    // Vector order: red_a orange_a green_a red_b orange_b green_b walk ped_waiting
    localparam logic [7:0] ARO  = 8'b11010000;
    localparam logic [7:0] AG   = 8'b00110000;
    localparam logic [7:0] AO   = 8'b01010000;
    localparam logic [7:0] ALLR = 8'b10010000;
    localparam logic [7:0] BRO  = 8'b10011000;
    localparam logic [7:0] BG   = 8'b10000100;
    localparam logic [7:0] BO   = 8'b10001000;
    localparam logic [7:0] WLK  = 8'b10010010;
    localparam logic [7:0] FL1  = 8'b01001000;
    localparam logic [7:0] FL0  = 8'b00000000;
    localparam logic [7:0] PED  = 8'b00000001;

    traffic_intersection dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .flash_en   (flash_en),
        .red_a      (red_a),
        .orange_a   (orange_a),
        .green_a    (green_a),
        .red_b      (red_b),
        .orange_b   (orange_b),
        .green_b    (green_b),
        .walk       (walk),
        .ped_waiting(ped_waiting)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {red_a, orange_a, green_a, red_b, orange_b, green_b, walk, ped_waiting};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, exp);
        end
    endtask

    task automatic full_period(input string tag);
        run({tag, "_aro"}, ARO, 1);
        run({tag, "_ag"},  AG,  6);
        run({tag, "_ao"},  AO,  1);
        run({tag, "_ar1"}, ALLR, 1);
        run({tag, "_bro"}, BRO, 1);
        run({tag, "_bg"},  BG,  4);
        run({tag, "_bo"},  BO,  1);
        run({tag, "_ar2"}, ALLR, 1);
    endtask

    initial begin
        rst = 1'b1; ped_req = 1'b0; flash_en = 1'b0;

        // Reset and two undisturbed periods
        run("reset", ALLR, 2);
        rst = 1'b0;
        full_period("p1");
        full_period("p2");

        // Press on first A_GREEN cycle: green cut to 2 cycles, walk after ALL_RED_1
        run("s2_aro", ARO, 1);
        run("s2_ag0", AG, 1);
        ped_req = 1'b1;
        run("s2_ag1", AG | PED, 1);
        ped_req = 1'b0;
        run("s2_ao", AO | PED, 1);
        run("s2_ar1", ALLR | PED, 1);
        run("s2_walk", WLK, 3);
        run("s2_bro", BRO, 1);
        run("s2_bg", BG, 4);
        run("s2_bo", BO, 1);
        run("s2_ar2", ALLR, 1);

        // Press on A_GREEN cnt=4, then button held through WALK
        run("s3_aro", ARO, 1);
        run("s3_ag", AG, 5);
        ped_req = 1'b1;
        run("s3_ag5", AG | PED, 1);
        ped_req = 1'b0;
        run("s3_ao", AO | PED, 1);
        run("s3_ar1", ALLR | PED, 1);
        run("s4_walk0", WLK, 1);
        ped_req = 1'b1;
        run("s4_walk", WLK, 2);
        run("s4_bro", BRO, 1);
        ped_req = 1'b0;
        run("s4_bg", BG, 4);
        run("s4_bo", BO, 1);
        run("s4_ar2", ALLR, 1);
        run("s4_aro", ARO, 1);

        // Flash entered from B_GREEN with a pending request
        run("s5_ag", AG, 6);
        run("s5_ao", AO, 1);
        run("s5_ar1", ALLR, 1);
        run("s5_bro", BRO, 1);
        run("s5_bg0", BG, 1);
        ped_req = 1'b1;
        run("s5_bg1", BG | PED, 1);
        ped_req = 1'b0;
        flash_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("s5_flash", ((i / 5) % 2 == 0) ? FL1 : FL0);
            if (i == 1) ped_req = 1'b1;
            if (i == 3) ped_req = 1'b0;
        end
        flash_en = 1'b0;
        run("s5_ar2", ALLR, 1);
        run("s5_aro", ARO, 1);

        // Reset mid B_GREEN with a request pending
        run("s6_ag", AG, 6);
        run("s6_ao", AO, 1);
        run("s6_ar1", ALLR, 1);
        run("s6_bro", BRO, 1);
        run("s6_bg0", BG, 1);
        ped_req = 1'b1;
        run("s6_bg1", BG | PED, 1);
        ped_req = 1'b0;
        rst = 1'b1;
        run("s6_rst", ALLR, 1);
        rst = 1'b0;
        full_period("s6_p");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
